axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-requester arbiter that shares one AXI read path (address channel plus read-data channel) between two masters. It grants one requester at a time with round-robin priority. It forwards that requester's address to the downstream slave, then routes the whole read burst back to it until `rlast`. It sits between two read-issuing DMA/engine blocks and the single downstream read port. Only one burst is outstanding at any time.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: R-channel watchdog limit in cycles. Used only with `AXI_RD_ARB_TIMEOUT_EN`.

Ports:
- `clk`  input  1  single clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `s0_a`  `AXI_A_IF.DST`  –  requester 0 read-address channel.
- `s0_r`  `AXI_R_IF.SRC`  –  requester 0 read-data channel.
- `s1_a`  `AXI_A_IF.DST`  –  requester 1 read-address channel.
- `s1_r`  `AXI_R_IF.SRC`  –  requester 1 read-data channel.
- `m_a`  `AXI_A_IF.SRC`  –  downstream read-address channel.
- `m_r`  `AXI_R_IF.DST`  –  downstream read-data channel.
- `grant_o`  output  2  one-hot current owner; `2'b00` in IDLE.
- `timeout_o`  output  1  one-cycle pulse on watchdog expiry. Tied 0 when the feature is compiled out.

## Operation
- State machine `IDLE → ADDR → DATA → IDLE`, with a registered `owner` bit and a registered `prio` bit (the requester favoured next).
- **IDLE**
  - All `aready`, `rvalid`, `m_a.avalid` and `m_r.rready` are 0.
  - If exactly one requester has `avalid`=1, latch it as `owner`.
  - If both have `avalid`=1, latch `prio` as `owner`.
  - Go to ADDR.
- **ADDR**
  - `m_a.{avalid,aid,aaddr,alen,asize,aburst}` pass combinationally from `s[owner]`.
  - `s[owner].aready` = `m_a.aready`. The other requester's `aready` = 0.
  - On the `m_a` handshake, go to DATA.
  - No ID remapping; `aid` passes unchanged.
- **DATA**
  - `s[owner].r{valid,id,data,resp,last}` pass combinationally from `m_r`.
  - `m_r.rready` = `s[owner].rready`. The other requester sees `rvalid`=0.
  - A beat handshakes when `rvalid` and `rready` are both 1.
  - On a handshake with `rlast`=1: go to IDLE and set `prio` = ~`owner`.
- Requests are never dropped. A non-granted requester holds `avalid` and is served in the next arbitration.
- `alen` is not tracked; burst end is determined only by `rlast`.
- **Reset** (asserted at any time, including mid-burst):
  - State = IDLE, `owner`=0, `prio`=0 (requester 0 favoured), `grant_o`=0, `timeout_o`=0.
  - All handshake outputs go to 0 immediately.
  - The in-flight burst is abandoned; no recovery.

## Timing
- Arbitration latency: `avalid` sampled in IDLE at edge N gives `m_a.avalid`=1 in the cycle after edge N.
- The address path and R path add zero cycles each (combinational through the mux).
- Turnaround: after the `rlast` handshake at edge N, IDLE lasts one cycle. The next grant is registered at edge N+1 and `m_a.avalid` rises in the cycle after N+1.
- Back-to-back bursts from alternating requesters therefore cost 2 idle cycles on `m_a`.
- `grant_o` is registered and valid during ADDR and DATA.
- `m_a.aready` and `m_r.rvalid` may be held high by the slave; only the owner ever completes a handshake.

## Configuration
- Macro: `AXI_RD_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in DATA, clears on every R handshake, and clears on leaving DATA.
  - When it reaches `TIMEOUT_CYCLES`-1 without a handshake, `timeout_o` pulses for one cycle.
  - The state is forced to IDLE and `prio` flips.
  - The counter width is `$clog2(TIMEOUT_CYCLES)`.
- **Undefined:** no counter, `timeout_o` = 0 constant, DATA waits indefinitely for `rlast`.

## Structure
- The shared params package holds:
  - the existing `axi_id_t`, `axi_addr_t`, `axi_len_t`, `axi_size_t`, `axi_burst_t`, `axi_data_t` and `axi_resp_t` typedefs;
  - new `arb_state_t` enum `{ARB_IDLE, ARB_ADDR, ARB_DATA}`;
  - new `ARB_TIMEOUT_DEFAULT` = 1024.
- Sub-module `rr_pick2`: combinational two-way round-robin picker. Inputs are `req[1:0]` and `prio`; outputs are `sel` and `any`. Instantiated once.

## Test plan
- **Single request:** s0 reads `aid`=3, `aaddr`=0x1000, `alen`=3. `m_a` shows the same fields one cycle after `avalid`, `grant_o`=01, and s0 receives 4 beats with `rlast` on the 4th. s1 sees `rvalid`=0 throughout.
- **Simultaneous after reset:** s0 and s1 assert in the same cycle. s0 is served first (`prio`=0), then s1 with 2 idle cycles on `m_a` between them. `grant_o` sequence is 01, 00, 10.
- **Fairness:** s0 and s1 both continuously issue 1-beat reads, 6 each. Grants alternate strictly s0, s1, s0, … and no requester is served twice in a row.
- **Backpressure:** in DATA, s1 holds `rready`=0 for 5 cycles while the slave holds `rvalid`. `m_r.rready`=0 and data stays stable. The burst completes when `rready` rises.
- **Reset mid-burst:** `rst_n` goes low after beat 2 of 4. All `aready`/`rvalid`/`avalid`/`rready` outputs drop to 0 at once, `grant_o`=00, and the next request is arbitrated with s0 favoured.
- **Timeout (`AXI_RD_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):** the slave stalls R for 16 cycles after the address handshake. `timeout_o` pulses once, the state returns to IDLE, and a pending s1 request is granted next.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI read-channel types and arbiter constants for axi_rd_arbiter.
package axi_rd_arbiter_pkg;

  typedef logic [3:0]  axi_id_t;
  typedef logic [31:0] axi_addr_t;
  typedef logic [7:0]  axi_len_t;
  typedef logic [2:0]  axi_size_t;
  typedef logic [1:0]  axi_burst_t;
  typedef logic [31:0] axi_data_t;
  typedef logic [1:0]  axi_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: o_sel names the winner, o_any flags a request.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic       o_sel,
  output logic       o_any
);

  assign o_any = |i_req;
  // A lone requester wins outright; prio only breaks a tie.
  assign o_sel = (&i_req) ? i_prio : i_req[1];

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read path between two requesters, one burst at a time.
// Optional R-channel watchdog enabled by defining AXI_RD_ARB_TIMEOUT_EN.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  // requester 0
  input  logic       i_s0_a_avalid,
  output logic       o_s0_a_aready,
  input  axi_id_t    i_s0_a_aid,
  input  axi_addr_t  i_s0_a_aaddr,
  input  axi_len_t   i_s0_a_alen,
  input  axi_size_t  i_s0_a_asize,
  input  axi_burst_t i_s0_a_aburst,
  output logic       o_s0_r_rvalid,
  input  logic       i_s0_r_rready,
  output axi_id_t    o_s0_r_rid,
  output axi_data_t  o_s0_r_rdata,
  output axi_resp_t  o_s0_r_rresp,
  output logic       o_s0_r_rlast,
  // requester 1
  input  logic       i_s1_a_avalid,
  output logic       o_s1_a_aready,
  input  axi_id_t    i_s1_a_aid,
  input  axi_addr_t  i_s1_a_aaddr,
  input  axi_len_t   i_s1_a_alen,
  input  axi_size_t  i_s1_a_asize,
  input  axi_burst_t i_s1_a_aburst,
  output logic       o_s1_r_rvalid,
  input  logic       i_s1_r_rready,
  output axi_id_t    o_s1_r_rid,
  output axi_data_t  o_s1_r_rdata,
  output axi_resp_t  o_s1_r_rresp,
  output logic       o_s1_r_rlast,
  // downstream slave
  output logic       o_m_a_avalid,
  input  logic       i_m_a_aready,
  output axi_id_t    o_m_a_aid,
  output axi_addr_t  o_m_a_aaddr,
  output axi_len_t   o_m_a_alen,
  output axi_size_t  o_m_a_asize,
  output axi_burst_t o_m_a_aburst,
  input  logic       i_m_r_rvalid,
  output logic       o_m_r_rready,
  input  axi_id_t    i_m_r_rid,
  input  axi_data_t  i_m_r_rdata,
  input  axi_resp_t  i_m_r_rresp,
  input  logic       i_m_r_rlast,
  // status
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  arb_state_t r_state;
  logic       r_owner;
  logic       r_prio;
  logic [1:0] r_grant;

  logic w_sel;
  logic w_any;
  logic w_a_hs;
  logic w_r_hs;
  logic w_expire;

  rr_pick2 u_pick (
    .i_req  ({i_s1_a_avalid, i_s0_a_avalid}),
    .i_prio (r_prio),
    .o_sel  (w_sel),
    .o_any  (w_any)
  );

  assign w_a_hs = (r_state == ARB_ADDR) && o_m_a_avalid && i_m_a_aready;
  assign w_r_hs = (r_state == ARB_DATA) && i_m_r_rvalid && o_m_r_rready;

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // Expiry only when the limit is hit in a cycle with no beat accepted.
  assign w_expire = (r_state == ARB_DATA) && !w_r_hs &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if ((r_state != ARB_DATA) || w_r_hs || w_expire) r_cnt <= '0;
      else                                              r_cnt <= r_cnt + 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_expire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_grant <= 2'b00;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_owner <= w_sel;
            r_grant <= w_sel ? 2'b10 : 2'b01;
            r_state <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (w_a_hs) r_state <= ARB_DATA;
        end
        ARB_DATA: begin
          if ((w_r_hs && i_m_r_rlast) || w_expire) begin
            r_state <= ARB_IDLE;
            r_prio  <= ~r_owner;
            r_grant <= 2'b00;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign grant_o = r_grant;

  // NOTE: every output gets a default before the muxing below, so no path
  // through this block leaves a value held and no latch is inferred.
  always_comb begin
    o_m_a_avalid  = 1'b0;
    o_m_a_aid     = '0;
    o_m_a_aaddr   = '0;
    o_m_a_alen    = '0;
    o_m_a_asize   = '0;
    o_m_a_aburst  = '0;
    o_s0_a_aready = 1'b0;
    o_s1_a_aready = 1'b0;
    o_m_r_rready  = 1'b0;
    o_s0_r_rvalid = 1'b0;
    o_s0_r_rid    = '0;
    o_s0_r_rdata  = '0;
    o_s0_r_rresp  = '0;
    o_s0_r_rlast  = 1'b0;
    o_s1_r_rvalid = 1'b0;
    o_s1_r_rid    = '0;
    o_s1_r_rdata  = '0;
    o_s1_r_rresp  = '0;
    o_s1_r_rlast  = 1'b0;

    if (r_state == ARB_ADDR) begin
      if (r_owner) begin
        o_m_a_avalid  = i_s1_a_avalid;
        o_m_a_aid     = i_s1_a_aid;
        o_m_a_aaddr   = i_s1_a_aaddr;
        o_m_a_alen    = i_s1_a_alen;
        o_m_a_asize   = i_s1_a_asize;
        o_m_a_aburst  = i_s1_a_aburst;
        o_s1_a_aready = i_m_a_aready;
      end else begin
        o_m_a_avalid  = i_s0_a_avalid;
        o_m_a_aid     = i_s0_a_aid;
        o_m_a_aaddr   = i_s0_a_aaddr;
        o_m_a_alen    = i_s0_a_alen;
        o_m_a_asize   = i_s0_a_asize;
        o_m_a_aburst  = i_s0_a_aburst;
        o_s0_a_aready = i_m_a_aready;
      end
    end

    if (r_state == ARB_DATA) begin
      if (r_owner) begin
        o_s1_r_rvalid = i_m_r_rvalid;
        o_s1_r_rid    = i_m_r_rid;
        o_s1_r_rdata  = i_m_r_rdata;
        o_s1_r_rresp  = i_m_r_rresp;
        o_s1_r_rlast  = i_m_r_rlast;
        o_m_r_rready  = i_s1_r_rready;
      end else begin
        o_s0_r_rvalid = i_m_r_rvalid;
        o_s0_r_rid    = i_m_r_rid;
        o_s0_r_rdata  = i_m_r_rdata;
        o_s0_r_rresp  = i_m_r_rresp;
        o_s0_r_rlast  = i_m_r_rlast;
        o_m_r_rready  = i_s0_r_rready;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: table-driven cycle vectors plus directed
// sequences for fairness, backpressure, reset mid-burst and (AXI_RD_ARB_TIMEOUT_EN) timeout.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s0_avalid, s0_aready, s0_rvalid, s0_rready, s0_rlast;
  logic       s1_avalid, s1_aready, s1_rvalid, s1_rready, s1_rlast;
  axi_id_t    s0_rid, s1_rid, m_aid, m_rid;
  axi_data_t  s0_rdata, s1_rdata, m_rdata;
  axi_resp_t  s0_rresp, s1_rresp, m_rresp;
  axi_addr_t  m_aaddr;
  axi_len_t   m_alen;
  axi_size_t  m_asize;
  axi_burst_t m_aburst;
  logic       m_avalid, m_aready, m_rvalid, m_rready, m_rlast;
  logic [1:0] grant;
  logic       timeout;

  axi_rd_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_s0_a_avalid(s0_avalid), .o_s0_a_aready(s0_aready), .i_s0_a_aid(4'd3),
    .i_s0_a_aaddr(32'h0000_1000), .i_s0_a_alen(8'd3), .i_s0_a_asize(3'd2), .i_s0_a_aburst(2'd1),
    .o_s0_r_rvalid(s0_rvalid), .i_s0_r_rready(s0_rready), .o_s0_r_rid(s0_rid),
    .o_s0_r_rdata(s0_rdata), .o_s0_r_rresp(s0_rresp), .o_s0_r_rlast(s0_rlast),
    .i_s1_a_avalid(s1_avalid), .o_s1_a_aready(s1_aready), .i_s1_a_aid(4'd5),
    .i_s1_a_aaddr(32'h0000_2000), .i_s1_a_alen(8'd0), .i_s1_a_asize(3'd2), .i_s1_a_aburst(2'd1),
    .o_s1_r_rvalid(s1_rvalid), .i_s1_r_rready(s1_rready), .o_s1_r_rid(s1_rid),
    .o_s1_r_rdata(s1_rdata), .o_s1_r_rresp(s1_rresp), .o_s1_r_rlast(s1_rlast),
    .o_m_a_avalid(m_avalid), .i_m_a_aready(m_aready), .o_m_a_aid(m_aid),
    .o_m_a_aaddr(m_aaddr), .o_m_a_alen(m_alen), .o_m_a_asize(m_asize), .o_m_a_aburst(m_aburst),
    .i_m_r_rvalid(m_rvalid), .o_m_r_rready(m_rready), .i_m_r_rid(m_rid),
    .i_m_r_rdata(m_rdata), .i_m_r_rresp(m_rresp), .i_m_r_rlast(m_rlast),
    .grant_o(grant), .timeout_o(timeout)
  );

  assign m_rid   = 4'd0;
  assign m_rresp = 2'd0;

  int checks = 0;
  int errors = 0;
  int n_timeout = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {m_avalid, s0_aready, s1_aready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast, m_rready}
  function automatic logic [7:0] obs_ctl();
    return {m_avalid, s0_aready, s1_aready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast, m_rready};
  endfunction

  // in = {s0_avalid, s1_avalid, m_aready, m_rvalid, m_rlast, s0_rready, s1_rready}
  task automatic drive(input logic [6:0] in, input logic [31:0] rdata);
    {s0_avalid, s1_avalid, m_aready, m_rvalid, m_rlast, s0_rready, s1_rready} = in;
    m_rdata = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(7'b0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [6:0] in, input logic [31:0] rdata);
    @(negedge clk);
    drive(in, rdata);
    #1;
  endtask

  typedef struct {
    string       name;
    bit          do_rst;
    logic [6:0]  in;
    logic [31:0] rdata;
    logic [7:0]  e_ctl;
    logic [1:0]  e_grant;
    logic [43:0] e_addr;   // {aid, aaddr, alen}
    logic [63:0] e_rd;     // {s0_rdata, s1_rdata}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input bit rst, input logic [6:0] in,
                     input logic [31:0] rdata, input logic [7:0] ctl, input logic [1:0] g,
                     input logic [43:0] addr, input logic [63:0] rd);
    vec_t v;
    v.name = name; v.do_rst = rst; v.in = in; v.rdata = rdata;
    v.e_ctl = ctl; v.e_grant = g; v.e_addr = addr; v.e_rd = rd;
    vecs.push_back(v);
  endtask

  always @(negedge clk) if (rst_n && timeout === 1'b1) n_timeout++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, cyc;
    logic exp_turn;
    logic [43:0] a0, a1;
    a0 = {4'd3, 32'h0000_1000, 8'd3};
    a1 = {4'd5, 32'h0000_2000, 8'd0};

    drive(7'b0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctl", 128'(obs_ctl()), 128'(8'h00));
    check("reset_grant", 128'(grant), 128'(2'b00));
    check("reset_timeout", 128'(timeout), 128'(1'b0));
    rst_n = 1'b1;

    // Single s0 request: 4-beat burst; m_rvalid held during ADDR must not leak.
    add("t1_idle",  1, 7'b1000000, 32'h0,  8'b0000_0000, 2'b00, 44'h0, 64'h0);
    add("t1_addr",  0, 7'b1011000, 32'h0,  8'b1100_0000, 2'b01, a0,    64'h0);
    add("t1_beat0", 0, 7'b0001011, 32'hA0, 8'b0001_0001, 2'b01, 44'h0, {32'hA0, 32'h0});
    add("t1_beat1", 0, 7'b0001011, 32'hA1, 8'b0001_0001, 2'b01, 44'h0, {32'hA1, 32'h0});
    add("t1_beat2", 0, 7'b0001011, 32'hA2, 8'b0001_0001, 2'b01, 44'h0, {32'hA2, 32'h0});
    add("t1_beat3", 0, 7'b0001111, 32'hA3, 8'b0001_0101, 2'b01, 44'h0, {32'hA3, 32'h0});
    add("t1_after", 0, 7'b0000000, 32'h0,  8'b0000_0000, 2'b00, 44'h0, 64'h0);
    // Simultaneous requests after reset: s0 first, then s1 after the idle turnaround.
    add("t2_idle",  1, 7'b1100000, 32'h0,  8'b0000_0000, 2'b00, 44'h0, 64'h0);
    add("t2_addr0", 0, 7'b1110000, 32'h0,  8'b1100_0000, 2'b01, a0,    64'h0);
    add("t2_data0", 0, 7'b0101111, 32'hB0, 8'b0001_0101, 2'b01, 44'h0, {32'hB0, 32'h0});
    add("t2_turn",  0, 7'b0111111, 32'hB0, 8'b0000_0000, 2'b00, 44'h0, 64'h0);
    add("t2_addr1", 0, 7'b0111111, 32'hB0, 8'b1010_0000, 2'b10, a1,    64'h0);
    add("t2_data1", 0, 7'b0001111, 32'hB1, 8'b0000_1011, 2'b10, 44'h0, {32'h0, 32'hB1});
    add("t2_after", 0, 7'b0000000, 32'h0,  8'b0000_0000, 2'b00, 44'h0, 64'h0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      step(vecs[i].in, vecs[i].rdata);
      check({vecs[i].name, "_ctl"},   128'(obs_ctl()), 128'(vecs[i].e_ctl));
      check({vecs[i].name, "_grant"}, 128'(grant), 128'(vecs[i].e_grant));
      check({vecs[i].name, "_addr"},  128'({m_aid, m_aaddr, m_alen}), 128'(vecs[i].e_addr));
      check({vecs[i].name, "_rdata"}, 128'({s0_rdata, s1_rdata}), 128'(vecs[i].e_rd));
    end

    // Fairness: both keep issuing 1-beat reads; grants must alternate s0, s1, ...
    do_reset();
    n0 = 0; n1 = 0; cyc = 0; exp_turn = 1'b0;
    while ((n0 + n1 < 12) && (cyc < 200)) begin
      step({n0 < 6, n1 < 6, 5'b11111}, 32'h0);
      if (s0_aready && s0_avalid) begin
        check("fair_owner", 128'(grant), 128'(exp_turn ? 2'b10 : 2'b01));
        exp_turn = ~exp_turn; n0++;
      end else if (s1_aready && s1_avalid) begin
        check("fair_owner", 128'(grant), 128'(exp_turn ? 2'b10 : 2'b01));
        exp_turn = ~exp_turn; n1++;
      end
      cyc++;
    end
    check("fair_counts", 128'({n0[7:0], n1[7:0]}), 128'({8'd6, 8'd6}));

    // Backpressure: s1 owns DATA and holds rready low; s0 rready high must not matter.
    do_reset();
    step(7'b0100000, 32'h0);
    check("bp_idle_grant", 128'(grant), 128'(2'b00));
    step(7'b0110000, 32'h0);
    check("bp_addr", 128'(obs_ctl()), 128'(8'b1010_0000));
    for (int k = 0; k < 5; k++) begin
      step(7'b0001010, 32'hC5);
      check("bp_stall", 128'({obs_ctl(), grant, s1_rdata}), 128'({8'b0000_1000, 2'b10, 32'hC5}));
    end
    step(7'b0001011, 32'hC5);
    check("bp_release", 128'({obs_ctl(), s1_rdata}), 128'({8'b0000_1001, 32'hC5}));
    step(7'b0001111, 32'hC6);
    check("bp_last", 128'({obs_ctl(), s1_rdata}), 128'({8'b0000_1011, 32'hC6}));
    step(7'b0000000, 32'h0);
    check("bp_done_grant", 128'(grant), 128'(2'b00));

    // Reset mid-burst: a completed s0 burst first moves prio to s1.
    do_reset();
    step(7'b1000000, 32'h0);
    step(7'b1010000, 32'h0);
    step(7'b0001110, 32'hD0);
    step(7'b1010000, 32'h0);
    step(7'b1010000, 32'h0);
    step(7'b0001010, 32'hD1);
    step(7'b0001010, 32'hD2);
    @(negedge clk);
    drive(7'b1111111, 32'hD3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", 128'(obs_ctl()), 128'(8'h00));
    check("rst_mid_grant", 128'(grant), 128'(2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    drive(7'b1110000, 32'h0);
    step(7'b1110000, 32'h0);
    check("rst_rearb", 128'({grant, obs_ctl()}), 128'({2'b01, 8'b1100_0000}));

`ifdef AXI_RD_ARB_TIMEOUT_EN
    // Timeout: R stalls after the address handshake; s1 is pending throughout.
    do_reset();
    step(7'b1100000, 32'h0);
    step(7'b1110000, 32'h0);
    check("to_addr", 128'({grant, obs_ctl()}), 128'({2'b01, 8'b1100_0000}));
    for (int k = 0; k < 18; k++) begin
      step(7'b1110011, 32'h0);
      if (k == 15) check("to_before", 128'({timeout, grant}), 128'({1'b0, 2'b01}));
      if (k == 16) check("to_pulse",  128'({timeout, grant}), 128'({1'b1, 2'b00}));
      if (k == 17) check("to_regrant", 128'({timeout, grant, obs_ctl()}),
                         128'({1'b0, 2'b10, 8'b1010_0000}));
    end
    check("timeout_total", 128'(n_timeout), 128'(1));
`else
    check("timeout_total", 128'(n_timeout), 128'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
